// File: rtl/draw_scheduler_pkg.sv
// Shared types and field widths for the bitmap draw scheduler.
package draw_sched_pkg;

  localparam int unsigned X_W     = 9;
  localparam int unsigned Y_W     = 8;
  localparam int unsigned COLOR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/draw_scheduler_if.sv
// Drawer-facing and bitmap-facing signal bundle of the draw scheduler.
// master = drawers/bitmap side, slave = the scheduler itself.
interface draw_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import draw_sched_pkg::*;

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ-1:0]         draw_in;
  logic [NUM_REQ-1:0]         done_in;
  logic [NUM_REQ*X_W-1:0]     x_in;
  logic [NUM_REQ*Y_W-1:0]     y_in;
  logic [NUM_REQ*COLOR_W-1:0] color_in;

  logic [NUM_REQ-1:0]         start_out;
  logic [NUM_REQ-1:0]         grant;
  logic                       wr_en;
  logic [X_W-1:0]             x;
  logic [Y_W-1:0]             y;
  logic [COLOR_W-1:0]         color;
  logic                       busy;
  logic                       timeout_err;

  modport master (
    output req, draw_in, done_in, x_in, y_in, color_in,
    input  start_out, grant, wr_en, x, y, color, busy, timeout_err
  );

  modport slave (
    input  req, draw_in, done_in, x_in, y_in, color_in,
    output start_out, grant, wr_en, x, y, color, busy, timeout_err
  );

endinterface

// File: rtl/draw_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set request strictly after last_i,
// wrapping, so last_i = N-1 makes index 0 the first choice.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int LW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [LW-1:0] last_i,
  output logic [N-1:0]  winner_o,
  output logic [LW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    int unsigned k;
    winner_o = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    k        = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      k = (32'(last_i) + i) % N;
      if (!valid_o && req_i[LW'(k)]) begin
        valid_o            = 1'b1;
        idx_o              = LW'(k);
        winner_o[LW'(k)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Round-robin owner of the single bitmap write port; forwards the granted
// drawer's stream. Optional grant watchdog: DRAW_SCHED_TIMEOUT_EN.
module draw_scheduler
  import draw_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic              clk,
  input  logic              reset,
  draw_scheduler_if.slave   bus
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   pending_q, pending_d;
  logic [NUM_REQ-1:0]   start_q, start_d;
  logic [LW-1:0]        idx_q, idx_d;
  logic [LW-1:0]        last_q, last_d;
  logic                 wr_en_q, wr_en_d;
  logic [X_W-1:0]       x_q, x_d;
  logic [Y_W-1:0]       y_q, y_d;
  logic [COLOR_W-1:0]   color_q, color_d;

  logic [NUM_REQ-1:0]   arb_winner;
  logic [LW-1:0]        arb_idx;
  logic                 arb_valid;
  logic                 end_grant;
  logic                 tmo_hit;

  logic                 sel_draw, sel_done;
  logic [X_W-1:0]       sel_x;
  logic [Y_W-1:0]       sel_y;
  logic [COLOR_W-1:0]   sel_color;

  // Live req is OR'd in so an idle scheduler grants on the very next edge.
  rr_arbiter #(
    .N  (NUM_REQ),
    .LW (LW)
  ) u_arb (
    .req_i    (pending_q | bus.req),
    .last_i   (last_q),
    .winner_o (arb_winner),
    .idx_o    (arb_idx),
    .valid_o  (arb_valid)
  );

  always_comb begin
    sel_draw  = 1'b0;
    sel_done  = 1'b0;
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        sel_draw  = bus.draw_in[i];
        sel_done  = bus.done_in[i];
        sel_x     = bus.x_in[i*X_W +: X_W];
        sel_y     = bus.y_in[i*Y_W +: Y_W];
        sel_color = bus.color_in[i*COLOR_W +: COLOR_W];
      end
    end
  end

`ifdef DRAW_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    tmo_hit   = (state_q == RUN) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    if (state_q == START)    cnt_d = '0;
    else if (state_q == RUN) cnt_d = cnt_q + 1'b1;
    if (tmo_hit && !sel_done) timeout_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_err = timeout_q;
`else
  assign tmo_hit         = 1'b0;
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    idx_d     = idx_q;
    last_d    = last_q;
    start_d   = '0;
    end_grant = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid) begin
          grant_d = arb_winner;
          idx_d   = arb_idx;
          state_d = START;
        end
      end
      START: begin
        start_d = grant_q;
        if (sel_done) end_grant = 1'b1;
        else          state_d   = RUN;
      end
      RUN: begin
        if (sel_done || tmo_hit) end_grant = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (end_grant) begin
      grant_d = '0;
      last_d  = idx_q;
      state_d = IDLE;
    end
    // A req arriving in the grant's final cycle keeps the drawer pending.
    pending_d = (pending_q & ~(end_grant ? grant_q : '0)) | bus.req;

    wr_en_d = sel_draw;
    x_d     = sel_draw ? sel_x     : x_q;
    y_d     = sel_draw ? sel_y     : y_q;
    color_d = sel_draw ? sel_color : color_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      pending_q <= '0;
      start_q   <= '0;
      idx_q     <= '0;
      last_q    <= LW'(NUM_REQ - 1);
      wr_en_q   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      color_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      pending_q <= pending_d;
      start_q   <= start_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      x_q       <= x_d;
      y_q       <= y_d;
      color_q   <= color_d;
    end
  end

  assign bus.start_out = start_q;
  assign bus.grant     = grant_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.wr_en     = wr_en_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.color     = color_q;

endmodule
